// File: rtl/cellar_zone_thermostat.sv
// cellar_zone_thermostat: N_ZONES independent heat/cool/pause thermostats, each with a stepped temperature model
// Ports: clk, rst (sync, active-high); conf/conf_zone/conf_dt load a zone's desired temperature;
//   en, window_open, restart are per-zone controls; rtr/dtf are per-zone temperature buses (zone i at [i*TW +: TW]);
//   led is the per-zone state code (00 off/idle, 01 heat, 10 cool, 11 pause); ws flags pause.
// Macro CELLAR_AUTO_RESUME_EN: leave pause as soon as the window closes; restart is then unused.
module cellar_zone_thermostat #(
  parameter int N_ZONES = 2,
  parameter int TW = 6,
  parameter int HYST = 1,
  parameter int STEP_CYC = 10,
  parameter int T_INIT = 20
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   conf,
  input  logic [$clog2(N_ZONES > 1 ? N_ZONES : 2)-1:0] conf_zone,
  input  logic [TW-1:0]                          conf_dt,
  input  logic [N_ZONES-1:0]                     en,
  input  logic [N_ZONES-1:0]                     window_open,
  input  logic [N_ZONES-1:0]                     restart,
  output logic [N_ZONES*TW-1:0]                  rtr,
  output logic [N_ZONES*TW-1:0]                  dtf,
  output logic [2*N_ZONES-1:0]                   led,
  output logic [N_ZONES-1:0]                     ws
);
  localparam int SW = $clog2(STEP_CYC);
  localparam logic signed [TW+1:0] H = (TW+2)'(HYST);
  typedef enum logic [2:0] {OFF, IDLE, HEAT, COOL, PAUSE} state_t;
  for (genvar g = 0; g < N_ZONES; g++) begin : z
    state_t st, st_n;
    logic [TW-1:0] r, r_n, d;
    logic [SW-1:0] t, t_n;
    logic signed [TW+1:0] rs, ds;
    logic lo, hi, step, resume;
    // band limits computed two bits wider and signed so dtf-HYST and dtf+HYST never wrap
    assign rs = $signed({2'b00, r});
    assign ds = $signed({2'b00, d});
    assign lo = rs < ds - H;
    assign hi = rs > ds + H;
    assign step = t == SW'(STEP_CYC - 1);
`ifdef CELLAR_AUTO_RESUME_EN
    assign resume = !window_open[g];
`else
    assign resume = !window_open[g] && restart[g];
`endif
    always_comb begin
      st_n = st;
      t_n = '0;
      r_n = r;
      if (!en[g]) st_n = OFF;
      else if (window_open[g] && (st == IDLE || st == HEAT || st == COOL)) st_n = PAUSE;
      else if (st == PAUSE) st_n = resume ? IDLE : PAUSE;
      else if (st == OFF) st_n = IDLE;
      else if (st == IDLE) st_n = lo ? HEAT : hi ? COOL : IDLE;
      else if (st == HEAT ? r >= d : r <= d) st_n = IDLE;
      else begin
        t_n = step ? '0 : t + 1'b1;
        r_n = !step ? r : st == HEAT ? (&r ? r : r + 1'b1) : (|r ? r - 1'b1 : r);
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st <= OFF;
        t <= '0;
        r <= TW'(T_INIT);
        d <= TW'(T_INIT);
      end else begin
        st <= st_n;
        t <= t_n;
        r <= r_n;
        if (conf && int'(conf_zone) == g) d <= conf_dt;
      end
    end
    assign rtr[g*TW +: TW] = r;
    assign dtf[g*TW +: TW] = d;
    assign led[2*g +: 2] = st == HEAT ? 2'b01 : st == COOL ? 2'b10 : st == PAUSE ? 2'b11 : 2'b00;
    assign ws[g] = st == PAUSE;
  end
endmodule
